// File: rtl/maxpool_window_gen_pkg.sv
// Shared pooling package: default word width and image geometry used by the
// window generator and the 4-input max block.
package maxpool_window_gen_pkg;

  localparam int unsigned POOL_DATA_WIDTH = 32;
  localparam int unsigned POOL_IMG_WIDTH  = 8;
  localparam int unsigned POOL_IMG_HEIGHT = 8;

  // Index width for a counter spanning 0..n-1 (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// One-row pixel store: single write port, two combinational read ports.
module maxpool_line_buf
  import maxpool_window_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int unsigned DEPTH      = POOL_IMG_WIDTH,
  localparam int unsigned AW        = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr_a,
  output logic [DATA_WIDTH-1:0] rdata_a_c,
  input  logic [AW-1:0]         raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_b_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents need no reset: a row is always written before it is read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a_c = mem[raddr_a];
  assign rdata_b_c = mem[raddr_b];

endmodule

// File: rtl/maxpool_window_gen.sv
// Raster-stream to non-overlapping 2x2 window generator (stride 2) feeding
// the max-pool stage; one registered window per completed odd-row pair.
module maxpool_window_gen
  import maxpool_window_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int unsigned IMG_WIDTH  = POOL_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = POOL_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_In,
  input  logic                  Valid_In,
  output logic [DATA_WIDTH-1:0] Data_A,
  output logic [DATA_WIDTH-1:0] Data_B,
  output logic [DATA_WIDTH-1:0] Data_C,
  output logic [DATA_WIDTH-1:0] Data_D,
  output logic                  Valid_Out,
  output logic                  Frame_Done
);

  localparam int unsigned COL_W = idx_width(IMG_WIDTH);
  localparam int unsigned ROW_W = idx_width(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  if ((IMG_WIDTH % 2) != 0 || (IMG_HEIGHT % 2) != 0 ||
      IMG_WIDTH < 2 || IMG_HEIGHT < 2) begin : g_bad_geometry
    $error("maxpool_window_gen: IMG_WIDTH and IMG_HEIGHT must be even and >= 2");
  end

  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic [DATA_WIDTH-1:0] hold;

  logic                  lb_we_c;
  logic                  hold_we_c;
  logic                  win_c;
  logic                  last_c;
  logic [COL_W-1:0]      left_addr_c;
  logic [DATA_WIDTH-1:0] lb_left_c;
  logic [DATA_WIDTH-1:0] lb_right_c;

  // Beat classification: even rows fill the buffer, odd rows pair with it.
  always_comb begin
    lb_we_c     = Valid_In && !row[0];
    hold_we_c   = Valid_In &&  row[0] && !col[0];
    win_c       = Valid_In &&  row[0] &&  col[0];
    last_c      = (row == ROW_LAST) && (col == COL_LAST);
    left_addr_c = col - COL_W'(1);
  end

  maxpool_line_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (IMG_WIDTH)
  ) u_line_buf (
    .clk       (clk),
    .we        (lb_we_c),
    .waddr     (col),
    .wdata     (Data_In),
    .raddr_a   (left_addr_c),
    .rdata_a_c (lb_left_c),
    .raddr_b   (col),
    .rdata_b_c (lb_right_c)
  );

  // Raster position; advances only on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (Valid_In) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // Bottom-left candidate, consumed by the following odd-column beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (hold_we_c) begin
      hold <= Data_In;
    end
  end

  // Window output registers hold their value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Data_A     <= '0;
      Data_B     <= '0;
      Data_C     <= '0;
      Data_D     <= '0;
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      Valid_Out  <= win_c;
      Frame_Done <= win_c && last_c;
      if (win_c) begin
        Data_A <= lb_left_c;
        Data_B <= lb_right_c;
        Data_C <= hold;
        Data_D <= Data_In;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_window_gen.sv
// Directed bench for maxpool_window_gen: 4x4 frames (contiguous, gapped,
// back-to-back, mid-frame reset) and an 8x8 FP32 frame against a model.
module tb_maxpool_window_gen;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic        fd;
    int          beat;
  } win_t;

  logic        clk;
  logic        rst;
  logic [31:0] d4, d8;
  logic        v4in, v8in;
  logic [31:0] a4, b4, c4, dd4, a8, b8, c8, dd8;
  logic        vo4, fd4, vo8, fd8;

  int   tests;
  int   fails;
  int   beat4, beat8;
  bit   start8;
  logic [127:0] prev8;
  win_t q4[$];
  win_t q8[$];
  win_t tbl[4];
  win_t exp8[16];

  maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .Data_In(d4), .Valid_In(v4in),
    .Data_A(a4), .Data_B(b4), .Data_C(c4), .Data_D(dd4),
    .Valid_Out(vo4), .Frame_Done(fd4)
  );

  maxpool_window_gen #(.DATA_WIDTH(32), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
    .clk(clk), .rst(rst), .Data_In(d8), .Valid_In(v8in),
    .Data_A(a8), .Data_B(b8), .Data_C(c8), .Data_D(dd8),
    .Valid_Out(vo8), .Frame_Done(fd8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepted-beat counters (reset with the DUT) tag each window's arrival.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      beat4 <= 0;
      beat8 <= 0;
    end else begin
      if (v4in) beat4 <= beat4 + 1;
      if (v8in) beat8 <= beat8 + 1;
    end
  end

  // Window capture, sampled mid-cycle.
  always @(negedge clk) begin
    win_t w;
    if (vo4) begin
      w.a = a4; w.b = b4; w.c = c4; w.d = dd4; w.fd = fd4; w.beat = beat4;
      q4.push_back(w);
    end
    if (fd4 && !vo4) check("fd4_without_valid", 32'(fd4), 32'(vo4));
    if (vo8) begin
      w.a = a8; w.b = b8; w.c = c8; w.d = dd8; w.fd = fd8; w.beat = beat8;
      q8.push_back(w);
    end
    if (start8) begin
      if (!vo8) check("hold8", 32'({a8, b8, c8, dd8} == prev8), 32'd1);
      check("fd8_implies_valid", 32'(fd8 & ~vo8), 32'd0);
    end
    prev8 = {a8, b8, c8, dd8};
  end

  task automatic drive4(input logic [31:0] v, input bit gap);
    d4 = v; v4in = 1'b1;
    @(posedge clk); #1;
    v4in = 1'b0; d4 = 32'hDEADBEEF;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic frame4(input int offset, input bit gaps);
    for (int i = 1; i <= 16; i++) drive4(32'(i + offset), gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare captured 4x4 windows from index base against the table.
  task automatic cmp4(input string tag, input int base, input int n_exp, input int beat_base);
    int   f;
    win_t e, g;
    check({tag, " count"}, 32'(q4.size() - base), 32'(n_exp));
    for (int k = 0; k < n_exp; k++) begin
      if (base + k < q4.size()) begin
        f = k / 4;
        e = tbl[k % 4];
        g = q4[base + k];
        check({tag, " A"}, g.a, e.a + 32'(100 * f));
        check({tag, " B"}, g.b, e.b + 32'(100 * f));
        check({tag, " C"}, g.c, e.c + 32'(100 * f));
        check({tag, " D"}, g.d, e.d + 32'(100 * f));
        check({tag, " Frame_Done"}, 32'(g.fd), 32'(e.fd));
        check({tag, " beat"}, 32'(g.beat), 32'(e.beat + 16 * f + beat_base));
      end
    end
  endtask

  initial begin
    int base, bb, n;
    tests = 0; fails = 0; start8 = 1'b0;
    tbl[0] = '{a: 1,  b: 2,  c: 5,  d: 6,  fd: 1'b0, beat: 6};
    tbl[1] = '{a: 3,  b: 4,  c: 7,  d: 8,  fd: 1'b0, beat: 8};
    tbl[2] = '{a: 9,  b: 10, c: 13, d: 14, fd: 1'b0, beat: 14};
    tbl[3] = '{a: 11, b: 12, c: 15, d: 16, fd: 1'b1, beat: 16};
    for (int wr = 0; wr < 4; wr++) begin
      for (int wc = 0; wc < 4; wc++) begin
        n = 16 * wr + 2 * wc;
        exp8[wr * 4 + wc] = '{a: 32'h3F800000 + 32'(n), b: 32'h3F800000 + 32'(n + 1),
                              c: 32'h3F800000 + 32'(n + 8), d: 32'h3F800000 + 32'(n + 9),
                              fd: (wr == 3 && wc == 3), beat: 16 * wr + 2 * wc + 10};
      end
    end

    rst = 1'b1; v4in = 1'b0; v8in = 1'b0; d4 = '0; d8 = '0;
    idle(2);
    check("reset Valid_Out", 32'(vo4), 32'd0);
    check("reset Frame_Done", 32'(fd4), 32'd0);
    check("reset Data_A", a4, 32'd0);
    check("reset Data_D", dd4, 32'd0);
    rst = 1'b0;
    idle(1);

    base = q4.size(); bb = beat4;
    frame4(0, 1'b0); idle(3);
    cmp4("contig", base, 4, bb);

    base = q4.size(); bb = beat4;
    frame4(0, 1'b1); idle(3);
    cmp4("gapped", base, 4, bb);

    base = q4.size(); bb = beat4;
    frame4(0, 1'b0); frame4(100, 1'b0); idle(3);
    cmp4("b2b", base, 8, bb);

    // Partial frame, asynchronous reset between edges, then a clean frame.
    for (int i = 1; i <= 7; i++) drive4(32'(i), 1'b0);
    rst = 1'b1;
    #1;
    check("midreset Valid_Out", 32'(vo4), 32'd0);
    check("midreset Data_A", a4, 32'd0);
    check("midreset Data_B", b4, 32'd0);
    check("midreset Data_C", c4, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    base = q4.size();
    frame4(0, 1'b0); idle(3);
    cmp4("after_reset", base, 4, 0);

    // 8x8 FP32 frame with random gaps, bit-exact against the model.
    start8 = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      d8 = 32'h3F800000 + 32'(i); v8in = 1'b1;
      @(posedge clk); #1;
      v8in = 1'b0; d8 = 32'hCAFEF00D;
    end
    idle(4);
    check("8x8 count", 32'(q8.size()), 32'd16);
    for (int k = 0; k < 16; k++) begin
      if (k < q8.size()) begin
        check("8x8 A", q8[k].a, exp8[k].a);
        check("8x8 B", q8[k].b, exp8[k].b);
        check("8x8 C", q8[k].c, exp8[k].c);
        check("8x8 D", q8[k].d, exp8[k].d);
        check("8x8 Frame_Done", 32'(q8[k].fd), 32'(exp8[k].fd));
        check("8x8 beat", 32'(q8[k].beat), 32'(exp8[k].beat));
      end
    end
    start8 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/maxpool_window_gen.md
MAXPOOL_WINDOW_GEN -- requirements
Module: maxpool_window_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FP32 word width.
REQ-002 SHALL have parameter IMG_WIDTH, default 8, pixels per row; even, >=2.
REQ-003 SHALL have parameter IMG_HEIGHT, default 8, rows per frame; even, >=2.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port Data_In, input, DATA_WIDTH, raster-order pixel.
REQ-007 SHALL have port Valid_In, input, 1, Data_In accepted on every clk edge where high.
REQ-008 SHALL have port Data_A, output, DATA_WIDTH, window top-left.
REQ-009 SHALL have port Data_B, output, DATA_WIDTH, window top-right.
REQ-010 SHALL have port Data_C, output, DATA_WIDTH, window bottom-left.
REQ-011 SHALL have port Data_D, output, DATA_WIDTH, window bottom-right.
REQ-012 SHALL have port Valid_Out, output, 1, one-cycle pulse marking a complete 2x2 window on Data_A..Data_D.
REQ-013 SHALL have port Frame_Done, output, 1, one-cycle pulse coincident with the last window of a frame.

Function
REQ-014 SHALL track column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1), advancing only on accepted beats.
REQ-015 col SHALL wrap to 0 after IMG_WIDTH-1 and increment row; row SHALL wrap to 0 after IMG_HEIGHT-1 (next beat starts a new frame).
REQ-016 On accepted beats with row even, SHALL write Data_In into line buffer entry col.
REQ-017 On accepted beats with row odd and col even, SHALL capture Data_In into a hold register (bottom-left candidate).
REQ-018 On accepted beat with row odd and col odd, SHALL register Data_A=linebuf[col-1], Data_B=linebuf[col], Data_C=hold, Data_D=Data_In, and assert Valid_Out on the next cycle (latency 1 clk from the completing beat).
REQ-019 Valid_Out SHALL be high for exactly one cycle per window; IMG_WIDTH*IMG_HEIGHT/4 pulses per frame; stride 2, no overlap.
REQ-020 Data_A..Data_D SHALL hold their last value when Valid_Out is low.
REQ-021 Frame_Done SHALL pulse with the Valid_Out of the window at row=IMG_HEIGHT-1, col=IMG_WIDTH-1.
REQ-022 Gaps (Valid_In low) SHALL be allowed at any position, including mid-window; counters, line buffer and hold register SHALL be unchanged across gaps.
REQ-023 No backpressure: the consumer accepts every Valid_Out pulse; back-to-back windows SHALL be possible every 2 accepted beats.
REQ-024 Data SHALL be passed bit-exact; no arithmetic on pixel values.
REQ-025 Back-to-back frames with no idle cycle SHALL produce correct windows for both frames.

Reset
REQ-026 While rst high: col=0, row=0, hold=0, Data_A..Data_D=0, Valid_Out=0, Frame_Done=0, asynchronously.
REQ-027 Line buffer contents SHALL need no reset; a reset mid-frame SHALL discard the partial frame; the first beat after release is pixel (0,0).
REQ-028 Valid_Out SHALL never assert from stale line-buffer data following reset before a full even row has been written.

Structure
REQ-029 A shared pooling package SHALL hold DATA_WIDTH default and the default IMG_WIDTH/IMG_HEIGHT constants, used by this block and the 4-input max block.
REQ-030 The line buffer SHALL be a sub-module maxpool_line_buf (IMG_WIDTH x DATA_WIDTH, one write port, two combinational read ports).
REQ-031 Odd IMG_WIDTH or IMG_HEIGHT SHALL fail elaboration.

Verification
REQ-032 4x4 frame, pixels 1..16 contiguous -> windows (1,2,5,6),(3,4,7,8),(9,10,13,14),(11,12,15,16), each 1 clk after beats 6,8,14,16; Frame_Done with last.
REQ-033 Same frame with Valid_In low every other cycle -> identical windows and order; pulse count 4.
REQ-034 Two 4x4 frames back-to-back (1..16 then 101..116) -> 8 windows, second set (101,102,105,106)...; two Frame_Done pulses.
REQ-035 rst asserted after pixel 7, then full frame 1..16 -> no Valid_Out before new beat 6; windows as REQ-032.
REQ-036 8x8 frame, values 0x3F800000+n -> 16 windows, each bit-exact vs reference model; outputs unchanged between pulses.
